tri_proj_ctrl: RTL and testbench

//  Sequencer for the triangle perspective-projection stage. Accepts one homogeneous triangle per handshake,

---
 rtl/tri_proj_pkg.sv | 12 +
 rtl/tri_proj_wcalc.sv | 26 ++
 rtl/tri_proj_ctrl.sv | 139 +++++++++++++
 tb/tb_tri_proj_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tri_proj_pkg.sv
// rtl/tri_proj_pkg.sv - shared widths, triangle typedefs and sequencer states for the projection stage
package tri_proj_pkg;
  localparam int TP_WIDTH = 32;
  localparam int TP_FRAC  = 16;

  // Component order within a vertex: [0]=x, [1]=y, [2]=z, [3]=w.
  typedef logic [3:0][TP_WIDTH-1:0]      vertex_t;
  typedef vertex_t [2:0]                 tri_t;
  typedef logic [2:0][1:0][TP_WIDTH-1:0] scr_tri_t;

  typedef enum logic [2:0] {IDLE, WCALC, ISSUE, DRAIN, OUT} state_e;
endpackage

// File: rtl/tri_proj_wcalc.sv
// rtl/tri_proj_wcalc.sv - per-vertex projected depth w' = z * (1/d) and cull decision
module tri_proj_wcalc
  import tri_proj_pkg::*;
#(
  parameter int WIDTH = TP_WIDTH,
  parameter int FRAC  = TP_FRAC
) (
  input  logic [2:0][WIDTH-1:0] z_i,
  input  logic [WIDTH-1:0]      inv_d_i,
  output logic [2:0][WIDTH-1:0] w_o,
  output logic                  cull_o
);
  logic signed [2*WIDTH-1:0]    prod [3];
  logic [2:0][WIDTH-FRAC-1:0]   hi_unused;
  logic [2:0][FRAC-1:0]         lo_unused;
  logic [2:0]                   nonpos;

  for (genvar i = 0; i < 3; i++) begin : g_vtx
    assign prod[i] = $signed(z_i[i]) * $signed(inv_d_i);
    // Keep the Q(FRAC) window of the full product; the rest is dropped.
    assign {hi_unused[i], w_o[i], lo_unused[i]} = prod[i];
    assign nonpos[i] = ($signed(w_o[i]) <= 0);
  end

  assign cull_o = |nonpos;
endmodule

// File: rtl/tri_proj_ctrl.sv
// rtl/tri_proj_ctrl.sv - triangle projection sequencer driving a shared external divider
module tri_proj_ctrl
  import tri_proj_pkg::*;
#(
  parameter int WIDTH = TP_WIDTH,
  parameter int FRAC  = TP_FRAC
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         tri_valid_in,
  output logic                         tri_ready_out,
  input  logic [2:0][3:0][WIDTH-1:0]   tri_in,
  input  logic [WIDTH-1:0]             inv_d_in,
  output logic                         div_valid_out,
  input  logic                         div_ready_in,
  output logic [WIDTH-1:0]             div_num_out,
  output logic [WIDTH-1:0]             div_den_out,
  input  logic                         div_res_valid_in,
  input  logic [WIDTH-1:0]             div_res_in,
  output logic                         proj_valid_out,
  input  logic                         proj_ready_in,
  output logic [2:0][1:0][WIDTH-1:0]   proj_tri_out,
  output logic                         cull_out,
  output logic                         err_out
);
  state_e                     state_q;
  logic [2:0]                 issue_cnt_q, res_cnt_q;
  logic [2:0][1:0][WIDTH-1:0] xy_q, proj_q, tri_xy;
  logic [2:0][WIDTH-1:0]      z_q, wp_q, wp_d, tri_z, w_unused;
  logic [WIDTH-1:0]           inv_d_q, div_num_q, div_den_q;
  logic                       cull_d, tri_ready_q, div_valid_q, proj_valid_q, cull_q, err_q;
  logic [2:0]                 nxt;

  for (genvar v = 0; v < 3; v++) begin : g_split
    assign tri_xy[v][0] = tri_in[v][0];
    assign tri_xy[v][1] = tri_in[v][1];
    assign tri_z[v]     = tri_in[v][2];
    assign w_unused[v]  = tri_in[v][3];
  end

  tri_proj_wcalc #(.WIDTH(WIDTH), .FRAC(FRAC)) u_wcalc (
    .z_i     (z_q),
    .inv_d_i (inv_d_q),
    .w_o     (wp_d),
    .cull_o  (cull_d)
  );

  // Request index n maps to vertex n/2, component n%2.
  assign nxt = issue_cnt_q + 3'd1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      res_cnt_q    <= '0;
      xy_q         <= '0;
      z_q          <= '0;
      wp_q         <= '0;
      inv_d_q      <= '0;
      proj_q       <= '0;
      tri_ready_q  <= 1'b1;
      div_valid_q  <= 1'b0;
      div_num_q    <= '0;
      div_den_q    <= '0;
      proj_valid_q <= 1'b0;
      cull_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (tri_valid_in && tri_ready_q) begin
          xy_q        <= tri_xy;
          z_q         <= tri_z;
          inv_d_q     <= inv_d_in;
          proj_q      <= '0;
          tri_ready_q <= 1'b0;
          state_q     <= WCALC;
        end
        WCALC: begin
          wp_q <= wp_d;
          if (cull_d) begin
            cull_q       <= 1'b1;
            proj_valid_q <= 1'b1;
            state_q      <= OUT;
          end else begin
            div_valid_q <= 1'b1;
            div_num_q   <= xy_q[0][0];
            div_den_q   <= wp_d[0];
            state_q     <= ISSUE;
          end
        end
        ISSUE: if (div_ready_in) begin
          issue_cnt_q <= nxt;
          if (issue_cnt_q == 3'd5) begin
            div_valid_q <= 1'b0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            state_q     <= DRAIN;
          end else begin
            div_num_q <= xy_q[nxt[2:1]][nxt[0]];
            div_den_q <= wp_q[nxt[2:1]];
          end
        end
        DRAIN: if (res_cnt_q == 3'd6) begin
          proj_valid_q <= 1'b1;
          state_q      <= OUT;
        end
        OUT: if (proj_ready_in) begin
          proj_valid_q <= 1'b0;
          cull_q       <= 1'b0;
          proj_q       <= '0;
          issue_cnt_q  <= '0;
          res_cnt_q    <= '0;
          tri_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A quotient with nothing outstanding is a protocol error; its data is discarded.
      if (div_res_valid_in) begin
        if (res_cnt_q == issue_cnt_q) begin
          err_q <= 1'b1;
        end else begin
          proj_q[res_cnt_q[2:1]][res_cnt_q[0]] <= div_res_in;
          res_cnt_q <= res_cnt_q + 3'd1;
        end
      end
    end
  end

  assign tri_ready_out  = tri_ready_q & ~rst_in;
  assign div_valid_out  = div_valid_q;
  assign div_num_out    = div_num_q;
  assign div_den_out    = div_den_q;
  assign proj_valid_out = proj_valid_q;
  assign proj_tri_out   = proj_q;
  assign cull_out       = cull_q;
  assign err_out        = err_q;
endmodule

// File: tb/tb_tri_proj_ctrl.sv
// tb/tb_tri_proj_ctrl.sv - directed self-checking bench for tri_proj_ctrl with a latency-4 divider model
module tb_tri_proj_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, tri_valid, tri_ready, div_valid, div_ready, div_res_valid;
  logic                  proj_valid, proj_ready, cull, err, inj;
  logic [2:0][3:0][31:0] tri_v;
  logic [31:0]           inv_d, div_num, div_den, div_res;
  logic [2:0][1:0][31:0] proj_tri;

  int vectors = 0;
  int fails   = 0;
  int hs_cnt  = 0;
  int base, n;
  logic [3:0]       pv = '0;
  logic [3:0][31:0] pd = '0;

  tri_proj_ctrl dut (
    .clk_in(clk), .rst_in(rst), .tri_valid_in(tri_valid), .tri_ready_out(tri_ready),
    .tri_in(tri_v), .inv_d_in(inv_d), .div_valid_out(div_valid), .div_ready_in(div_ready),
    .div_num_out(div_num), .div_den_out(div_den), .div_res_valid_in(div_res_valid),
    .div_res_in(div_res), .proj_valid_out(proj_valid), .proj_ready_in(proj_ready),
    .proj_tri_out(proj_tri), .cull_out(cull), .err_out(err)
  );

  function automatic logic [31:0] qdiv(input logic [31:0] num, input logic [31:0] den);
    logic signed [63:0] nn, dd;
    nn = $signed(num);
    nn = nn <<< 16;
    dd = $signed(den);
    if (dd == 0) return '0;
    return 32'(nn / dd);
  endfunction

  // External divider: in order, result valid 4 cycles after the request handshake.
  always @(posedge clk) begin
    if (rst) begin
      pv            <= '0;
      div_res_valid <= 1'b0;
      div_res       <= '0;
    end else begin
      if (div_valid && div_ready) hs_cnt <= hs_cnt + 1;
      pv            <= {pv[2:0], div_valid & div_ready};
      pd            <= {pd[2:0], qdiv(div_num, div_den)};
      div_res_valid <= pv[3] | inj;
      div_res       <= pd[3];
    end
  end

  function automatic logic [2:0][3:0][31:0] mk_tri(
      input logic [31:0] x0, y0, z0, x1, y1, z1, x2, y2, z2);
    logic [2:0][3:0][31:0] t;
    t[0] = {32'h10000, z0, y0, x0};
    t[1] = {32'h10000, z1, y1, x1};
    t[2] = {32'h10000, z2, y2, x2};
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_proj(input string tag, input logic [5:0][31:0] e);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_c%0d", tag, i), proj_tri[i/2][i%2], e[i]);
  endtask

  task automatic send_tri(input logic [2:0][3:0][31:0] t, input logic [31:0] d);
    int k;
    tri_v     = t;
    inv_d     = d;
    tri_valid = 1'b1;
    k = 0;
    while (!tri_ready && k < 20) begin tick; k++; end
    chk("accept_ready", tri_ready, 1'b1);
    tick;
    tri_valid = 1'b0;
  endtask

  task automatic wait_proj(input string tag);
    int k;
    k = 0;
    while (!proj_valid && k < 200) begin tick; k++; end
    chk(tag, proj_valid, 1'b1);
  endtask

  task automatic release_out;
    proj_ready = 1'b1;
    tick;
    proj_ready = 1'b0;
  endtask

  logic [2:0][3:0][31:0] t1, t2, t3;
  logic [5:0][31:0]      e1, e2, ez;

  initial begin
    t1 = mk_tri(32'h40000, 32'h20000, 32'h20000, 32'h20000, 32'h20000, 32'h10000,
                32'hFFFD0000, 32'h60000, 32'h30000);
    e1 = {32'h20000, 32'hFFFF0000, 32'h20000, 32'h20000, 32'h10000, 32'h20000};
    t2 = mk_tri(32'h40000, 32'hFFFE0000, 32'h40000, 32'h20000, 32'h20000, 32'h20000,
                32'hFFFD0000, 32'h60000, 32'h60000);
    e2 = {32'h20000, 32'hFFFF0000, 32'h20000, 32'h20000, 32'hFFFF0000, 32'h20000};
    t3 = t1;
    t3[1][2] = 32'h0;
    ez = '0;

    rst = 1'b1; tri_valid = 1'b0; tri_v = '0; inv_d = '0;
    div_ready = 1'b1; proj_ready = 1'b0; inj = 1'b0;
    repeat (3) tick;
    chk("rst_tri_ready", tri_ready, 1'b0);
    chk("rst_div_valid", div_valid, 1'b0);
    chk("rst_proj_valid", proj_valid, 1'b0);
    chk("rst_cull", cull, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    tick;
    chk("idle_tri_ready", tri_ready, 1'b1);

    // Unit-scale projection, no stalls.
    base = hs_cnt;
    send_tri(t1, 32'h10000);
    wait_proj("t1_valid");
    chk("t1_cull", cull, 1'b0);
    chk_proj("t1", e1);
    chk("t1_hs", hs_cnt - base, 6);
    release_out;
    chk("t1_valid_drop", proj_valid, 1'b0);
    chk("t1_ready_back", tri_ready, 1'b1);

    // Half-scale 1/d.
    send_tri(t2, 32'h8000);
    wait_proj("t2_valid");
    chk_proj("t2", e2);
    release_out;

    // Zero depth on v1 culls straight from WCALC.
    base = hs_cnt;
    send_tri(t3, 32'h10000);
    chk("t3_wcalc_valid", proj_valid, 1'b0);
    chk("t3_wcalc_div", div_valid, 1'b0);
    tick;
    chk("t3_valid", proj_valid, 1'b1);
    chk("t3_cull", cull, 1'b1);
    chk("t3_div", div_valid, 1'b0);
    chk_proj("t3", ez);
    chk("t3_hs", hs_cnt - base, 0);
    release_out;
    chk("t3_cull_clear", cull, 1'b0);

    // Divider stall mid-issue and output backpressure.
    base = hs_cnt;
    send_tri(t1, 32'h10000);
    n = 0;
    while (hs_cnt - base < 2 && n < 50) begin tick; n++; end
    div_ready = 1'b0;
    chk("t4_hs2", hs_cnt - base, 2);
    repeat (5) begin
      tick;
      chk("t4_stall_valid", div_valid, 1'b1);
      chk("t4_stall_num", div_num, 32'h20000);
      chk("t4_stall_den", div_den, 32'h10000);
    end
    div_ready = 1'b1;
    wait_proj("t4_valid");
    repeat (3) tick;
    chk("t4_held_valid", proj_valid, 1'b1);
    chk_proj("t4", e1);
    chk("t4_hs", hs_cnt - base, 6);
    release_out;

    // Reset during ISSUE aborts the triangle.
    base = hs_cnt;
    send_tri(t1, 32'h10000);
    n = 0;
    while (hs_cnt - base < 3 && n < 50) begin tick; n++; end
    rst = 1'b1;
    tick;
    chk("t5_div_valid", div_valid, 1'b0);
    chk("t5_div_num", div_num, 32'h0);
    chk("t5_proj_valid", proj_valid, 1'b0);
    chk("t5_cull", cull, 1'b0);
    chk("t5_err", err, 1'b0);
    chk("t5_proj0", proj_tri[0][0], 32'h0);
    chk("t5_ready_in_rst", tri_ready, 1'b0);
    rst = 1'b0;
    tick;
    chk("t5_ready", tri_ready, 1'b1);
    base = hs_cnt;
    send_tri(t1, 32'h10000);
    wait_proj("t5_valid");
    chk_proj("t5", e1);
    chk("t5_hs", hs_cnt - base, 6);
    chk("t5_err_after", err, 1'b0);
    release_out;

    // Spurious quotient while idle.
    chk("t6_err_before", err, 1'b0);
    inj = 1'b1;
    tick;
    inj = 1'b0;
    tick;
    chk("t6_err", err, 1'b1);
    chk("t6_proj_valid", proj_valid, 1'b0);
    repeat (5) tick;
    chk("t6_err_sticky", err, 1'b1);
    chk("t6_proj_valid_late", proj_valid, 1'b0);
    chk("t6_ready", tri_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
